// File: rtl/psg_pkg.sv
// ---------------------------------------------------------------------------
// psg_pkg
// Shared definitions for the PSG sound core: envelope shape bit positions,
// envelope resolution, default period width, the envelope run/stop state
// encoding and a decoded view of the 4-bit shape register.
// No ports (package).
// ---------------------------------------------------------------------------
package psg_pkg;

    localparam int PW_DEF         = 16;
    localparam int ENV_STEPS_LOG2 = 5;

    localparam int SHAPE_HOLD = 0;
    localparam int SHAPE_ALT  = 1;
    localparam int SHAPE_ATT  = 2;
    localparam int SHAPE_CONT = 3;

    typedef enum logic {
        ENV_STOP = 1'b0,
        ENV_RUN  = 1'b1
    } env_state_e;

    // Field order matches the register layout: [3]=CONT [2]=ATT [1]=ALT [0]=HOLD.
    typedef struct packed {
        logic cont;
        logic att;
        logic alt;
        logic hold;
    } env_shape_t;

    function automatic env_shape_t decode_shape(input logic [3:0] shape);
        env_shape_t s;
        s.cont = shape[SHAPE_CONT];
        s.att  = shape[SHAPE_ATT];
        s.alt  = shape[SHAPE_ALT];
        s.hold = shape[SHAPE_HOLD];
        return s;
    endfunction

endpackage

// File: rtl/psg_env_gen_if.sv
// ---------------------------------------------------------------------------
// psg_env_gen_if
// Control/status bundle between the PSG register block (master) and the
// envelope generator (slave).
//   cen      : step-rate enable pulse from the clock-enable divider
//   period   : envelope period (0 behaves as 1)
//   shape    : [3]=CONT [2]=ATT [1]=ALT [0]=HOLD
//   restart  : one-clk strobe on a shape register write
//   env      : current envelope level
//   env_end  : one-clk pulse after a full ramp completes
//   stopped  : envelope frozen (hold or one-shot finished)
// ---------------------------------------------------------------------------
interface psg_env_gen_if
    import psg_pkg::*;
#(
    parameter int PW         = PW_DEF,
    parameter int STEPS_LOG2 = ENV_STEPS_LOG2
);

    logic                  cen;
    logic [PW-1:0]         period;
    logic [3:0]            shape;
    logic                  restart;
    logic [STEPS_LOG2-1:0] env;
    logic                  env_end;
    logic                  stopped;

    modport master (
        output cen,
        output period,
        output shape,
        output restart,
        input  env,
        input  env_end,
        input  stopped
    );

    modport slave (
        input  cen,
        input  period,
        input  shape,
        input  restart,
        output env,
        output env_end,
        output stopped
    );

endinterface

// File: rtl/psg_period_cnt.sv
// ---------------------------------------------------------------------------
// psg_period_cnt
// Enable-gated period divider shared by the tone, noise and envelope
// generators. Counts cen pulses and asserts tick on the cen that reaches the
// programmed period.
//   clk, rst_n : system clock, async active-low reset
//   cen_i      : count enable (one-clk pulse)
//   clr_i      : synchronous clear, wins over counting
//   period_i   : divide ratio, 0 behaves as 1
//   tick_o     : combinational, high on the cen that completes a period
// ---------------------------------------------------------------------------
module psg_period_cnt
    import psg_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          clr_i,
    input  logic [PW-1:0] period_i,
    output logic          tick_o
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] last_cnt;

    // Terminal count is period-1, with period 0 folded onto period 1.
    // The >= compare means a period lowered below the current count fires on
    // the next cen instead of running the counter all the way round.
    always_comb begin
        last_cnt = (period_i == '0) ? '0 : (period_i - ONE);
        tick_o   = cen_i & (cnt_q >= last_cnt);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cen_i) begin
            cnt_d = tick_o ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/psg_env_gen.sv
// ---------------------------------------------------------------------------
// psg_env_gen
// PSG envelope generator. Divides the step-rate strobe by the envelope period
// and walks a 2^STEPS_LOG2-step amplitude ramp whose direction, repetition
// and end behaviour come from the 4-bit shape register.
//   clk, rst_n : system clock, async active-low reset
//   bus        : psg_env_gen_if slave (cen, period, shape, restart in;
//                env, env_end, stopped out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ENV_STOP | envelope frozen; ticks ignored (after reset, hold, one-shot)
// ENV_RUN  | each tick advances the step counter
// ---------------------------------------------------------------------------
module psg_env_gen
    import psg_pkg::*;
#(
    parameter int PW         = PW_DEF,
    parameter int STEPS_LOG2 = ENV_STEPS_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    psg_env_gen_if.slave        bus
);

    localparam logic [STEPS_LOG2-1:0] STEP_ONE = STEPS_LOG2'(1);
    localparam logic [STEPS_LOG2-1:0] STEP_MAX = '1;

    env_state_e            state_q;
    env_state_e            state_d;
    logic [STEPS_LOG2-1:0] step_q;
    logic [STEPS_LOG2-1:0] step_d;
    logic                  inv_q;
    logic                  inv_d;
    logic                  env_end_q;
    logic                  env_end_d;
    logic                  tick;
    env_shape_t            shp;

    psg_period_cnt #(
        .PW (PW)
    ) u_period_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen_i    (bus.cen),
        .clr_i    (bus.restart),
        .period_i (bus.period),
        .tick_o   (tick)
    );

    assign shp = decode_shape(bus.shape);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        inv_d     = inv_q;
        env_end_d = 1'b0;

        if (bus.restart) begin
            // Attack starts at 0 (inv=0), decay starts at full scale (inv=1).
            step_d  = '0;
            inv_d   = ~shp.att;
            state_d = ENV_RUN;
        end else if (tick && (state_q == ENV_RUN)) begin
            step_d = step_q + STEP_ONE;
            if (step_q == STEP_MAX) begin
                env_end_d = 1'b1;
                if (!shp.cont) begin
                    // One-shot: park at silence regardless of direction.
                    state_d = ENV_STOP;
                    inv_d   = 1'b0;
                end else if (shp.hold) begin
                    // step wraps to 0, so flipping inv holds the final level;
                    // with ALT the flip is skipped and the complement is held.
                    state_d = ENV_STOP;
                    inv_d   = inv_q ^ ~shp.alt;
                end else if (shp.alt) begin
                    inv_d = ~inv_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENV_STOP;
            step_q    <= '0;
            inv_q     <= 1'b0;
            env_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            inv_q     <= inv_d;
            env_end_q <= env_end_d;
        end
    end

    assign bus.env     = step_q ^ {STEPS_LOG2{inv_q}};
    assign bus.env_end = env_end_q;
    assign bus.stopped = (state_q == ENV_STOP);

endmodule

// File: tb/tb_psg_env_gen.sv
module tb_psg_env_gen;
    import psg_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    psg_env_gen_if #(.PW(16), .STEPS_LOG2(5)) bus ();

    psg_env_gen #(.PW(16), .STEPS_LOG2(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cen     = 1'b0;
        bus.period  = 16'd1;
        bus.shape   = 4'h0;
        bus.restart = 1'b0;

        // reset state
        #3;
        chk("rst_env", bus.env, 0);
        chk("rst_env_end", bus.env_end, 0);
        chk("rst_stopped", bus.stopped, 1);

        @(negedge clk);
        rst_n   = 1'b1;
        bus.cen = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_env", bus.env, 0);
        chk("idle_stopped", bus.stopped, 1);

        // shape 0x0 one-shot decay, period 1 then period 0
        for (int p = 1; p >= 0; p--) begin
            bus.period  = 16'(p);
            bus.shape   = 4'h0;
            bus.restart = 1'b1;
            @(negedge clk);
            bus.restart = 1'b0;
            for (int n = 0; n <= 40; n++) begin
                chk("s0_env", bus.env, (n < 32) ? 31 - n : 0);
                chk("s0_env_end", bus.env_end, (n == 32) ? 1 : 0);
                chk("s0_stopped", bus.stopped, (n >= 32) ? 1 : 0);
                @(negedge clk);
            end
        end

        // shape 0xD attack then hold at 31
        bus.period  = 16'd1;
        bus.shape   = 4'hD;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            chk("sD_env", bus.env, (n < 32) ? n : 31);
            chk("sD_env_end", bus.env_end, (n == 32) ? 1 : 0);
            chk("sD_stopped", bus.stopped, (n >= 32) ? 1 : 0);
            @(negedge clk);
        end

        // shape 0x8 repeating decay sawtooth
        bus.shape   = 4'h8;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        for (int n = 0; n <= 70; n++) begin
            chk("s8_env", bus.env, 31 - (n % 32));
            chk("s8_env_end", bus.env_end, (n > 0 && n % 32 == 0) ? 1 : 0);
            chk("s8_stopped", bus.stopped, 0);
            @(negedge clk);
        end

        // shape 0xE triangle starting with attack
        bus.shape   = 4'hE;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            chk("sE_env", bus.env, (((n / 32) % 2) == 0) ? (n % 32) : (31 - (n % 32)));
            chk("sE_env_end", bus.env_end, (n > 0 && n % 32 == 0) ? 1 : 0);
            chk("sE_stopped", bus.stopped, 0);
            @(negedge clk);
        end

        // restart coincident with a tick: restart wins, no advance
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        chk("rs_tick_env0", bus.env, 0);
        @(negedge clk);
        chk("rs_tick_env1", bus.env, 1);

        // shape 0xB, period 2, cen every 4 clks: 8 clks per level, hold 31
        bus.cen     = 1'b0;
        bus.shape   = 4'hB;
        bus.period  = 16'd2;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        for (int m = 0; m <= 270; m++) begin
            chk("sB_env", bus.env, (m < 256) ? (31 - m / 8) : 31);
            chk("sB_env_end", bus.env_end, (m == 256) ? 1 : 0);
            chk("sB_stopped", bus.stopped, (m >= 256) ? 1 : 0);
            bus.cen = ((m + 1) % 4 == 0);
            @(negedge clk);
        end

        // lowering the period below the running count fires on next cen
        bus.cen     = 1'b1;
        bus.shape   = 4'h8;
        bus.period  = 16'd100;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        repeat (50) @(negedge clk);
        chk("per_hold_env", bus.env, 31);
        bus.period = 16'd3;
        bus.cen    = 1'b0;
        @(negedge clk);
        chk("per_nocen_env", bus.env, 31);
        bus.cen = 1'b1;
        @(negedge clk);
        chk("per_drop_env", bus.env, 30);
        repeat (2) @(negedge clk);
        chk("per3_wait_env", bus.env, 30);
        @(negedge clk);
        chk("per3_tick_env", bus.env, 29);

        // async reset mid-ramp
        bus.period  = 16'd1;
        bus.shape   = 4'h0;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_env", bus.env, 17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_env", bus.env, 0);
        chk("mid_rst_stopped", bus.stopped, 1);
        chk("mid_rst_env_end", bus.env_end, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_env", bus.env, 0);
        chk("post_rst_stopped", bus.stopped, 1);
        chk("post_rst_env_end", bus.env_end, 0);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        chk("post_rst_restart_env", bus.env, 31);
        chk("post_rst_restart_stopped", bus.stopped, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psg_env_gen.md
Name: psg_env_gen

Overview:
- Envelope generator for the PSG sound core.
- Sits directly downstream of the PSG clock-enable divider and consumes its slow enable pulse (the 1/256 rate strobe) as its step enable.
- Divides that strobe by a programmable 16-bit envelope period and walks a 32-step, 5-bit amplitude ramp shaped by the 4-bit envelope shape register (CONT/ATT/ALT/HOLD).
- Output feeds the channel amplitude mux / volume DAC table.

Parameters:
PW, 16, width of envelope period register and period counter
STEPS_LOG2, 5, log2 of steps per envelope cycle; env output width (5 gives 32 steps, YM-style)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  step-rate clock enable from the divider; one-clk pulse
period  in  PW  envelope period; 0 is treated as 1
shape  in  4  [3]=CONT [2]=ATT [1]=ALT [0]=HOLD
restart  in  1  one-clk strobe, written when CPU writes the shape register
env  out  STEPS_LOG2  current envelope level
env_end  out  1  one-clk pulse when a 32-step cycle completes
stopped  out  1  high while the envelope is frozen (hold or one-shot done)

Behaviour:
- Reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset state:
  - per_cnt=0, step=0, inv=0, stop=1.
  - Outputs: env=0, env_end=0, stopped=1 (silent until first restart).
- Output decode:
  - env = step XOR {STEPS_LOG2{inv}}, decoded combinationally from registers; no extra pipeline stage.
  - stopped = stop.
- Step event (tick) = cen & (per_cnt >= period_eff-1), where period_eff = (period==0) ? 1 : period.
  - Comparison is >=, so lowering period mid-count never waits for a 2^PW wrap.
- Period counter:
  - On cen & !tick: per_cnt <= per_cnt+1.
  - On tick: per_cnt <= 0.
  - No change without cen.
  - The counter runs even while stop=1; harmless.
- On tick with stop=0: step <= step+1, mod 2^STEPS_LOG2.
- When step==max at a tick (the wrap), end-of-cycle rules apply:
  - env_end pulses for one clk in the cycle after the tick.
  - CONT=0: stop<=1, inv<=0, so env goes to 0 and holds.
  - CONT=1, HOLD=1: stop<=1, inv<=inv ^ ~ALT.
    - Result: holds at the final level (ALT=0) or its complement (ALT=1).
  - CONT=1, HOLD=0, ALT=1: inv<=~inv (triangle).
  - CONT=1, HOLD=0, ALT=0: inv unchanged (sawtooth).
- On tick with stop=1: step, inv and env are unchanged; env_end stays 0.
- restart (synchronous; takes precedence over a simultaneous tick):
  - per_cnt<=0, step<=0, inv<=~shape[2], stop<=0.
  - env reflects the new start level (0 for attack, 31 for decay) the clk after restart.
- shape/period changes without restart:
  - shape bits are sampled live at each wrap.
  - period is sampled live at each cen.
- env latency: changes one clk after the tick cycle.
- env_end is registered, 0 except for the single pulse.
- Reset asserted mid-cycle returns all state to reset values immediately (async).
- Release of reset is synchronised by the system reset block.

Decomposition:
- Shared package psg_pkg holds:
  - Shape bit indices: SHAPE_HOLD=0, SHAPE_ALT=1, SHAPE_ATT=2, SHAPE_CONT=3.
  - ENV_STEPS_LOG2=5.
  - The PW default.
- One sub-module: psg_period_cnt.
  - Parameterised PW-bit cen-gated counter with >= compare, zero-as-one rule and synchronous clear.
  - Outputs the tick.
  - Reused by the tone and noise generators.

Test Plan:
- Shape 0x0, period=1, cen every clk, restart → env 31,30,…,0 on successive clks. Then 0 forever; env_end exactly one pulse; stopped=1 from the wrap onward.
- Shape 0xD, period=1 → env 0..31, then held at 31 indefinitely; stopped=1 after the wrap.
- Shape 0x8 / 0xE, period=1 → 0x8: sawtooth 31..0 repeating, env_end every 32 clks. 0xE: triangle 0..31, 31..0, 0..31; stopped stays 0.
- Shape 0xB, period=2, cen every 4 clks → each level held 8 clks, 31..0, then hold 31. Checks the period divide and the ALT+HOLD complement rule.
- Period edges:
  - period=0 behaves identically to period=1.
  - With period=100 and per_cnt=50, write period=3 → tick on the next cen.
  - restart on the same clk as a tick → step=0, no advance.
- Reset: assert rst_n=0 mid-ramp (env=17) → env=0, stopped=1, env_end=0 immediately. After release, nothing moves until restart.
